// File: rtl/bram_axis_reader.sv
// Streams BRAM lines [start_index..bound_index] word-by-word on AXI4-Stream; first beat BRAM_LATENCY+2 cycles after start.
// Backpressure: tready low stalls the drain; at most two lines are buffered and one read is in flight.
module bram_axis_reader #(
  parameter int BRAM_DEPTH     = 12,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 36,
  parameter int BRAM_LATENCY   = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [BRAM_DEPTH-1:0]                start_index,
  input  logic [BRAM_DEPTH-1:0]                bound_index,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 bram_en,
  output logic [BRAM_DEPTH-1:0]                bram_addr,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_rdata,
  output logic [WORD_WIDTH-1:0]                m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast
);

  localparam int CW   = $clog2(WORDS_PER_LINE);
  localparam int CNTW = BRAM_DEPTH + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q;
  logic                     busy_q, done_q, bram_en_q;
  logic [BRAM_DEPTH-1:0]    addr_q;
  logic [CNTW-1:0]          fetch_left_q, drain_left_q;
  logic [BRAM_LATENCY-1:0]  lat_sr_q, lat_sr_d;
  logic [1:0]               full_q, full_d;
  logic                     fill_sel_q, drain_sel_q;
  logic [CW-1:0]            word_cnt_q;
  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] buf_q [2];

  logic            in_flight, capture, hs, line_end, last_beat, fetch_go;
  logic [CNTW-1:0] line_count;

  assign line_count = {1'b0, bound_index - start_index} + CNTW'(1);
  // A read stays in flight up to and including its capture cycle.
  assign in_flight  = bram_en_q | (|lat_sr_q);
  assign capture    = lat_sr_q[BRAM_LATENCY-1];
  assign hs         = m_axis_tvalid & m_axis_tready;
  assign line_end   = hs & (word_cnt_q == LAST_WORD);
  assign last_beat  = line_end & (drain_left_q == CNTW'(1));
  assign fetch_go   = (state_q == RUN) && (fetch_left_q != '0) && !in_flight && !full_q[fill_sel_q];

  always_comb begin
    lat_sr_d    = lat_sr_q << 1;
    lat_sr_d[0] = bram_en_q;
    full_d      = full_q;
    if (capture)  full_d[fill_sel_q]  = 1'b1;
    if (line_end) full_d[drain_sel_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bram_en_q    <= 1'b0;
      addr_q       <= '0;
      fetch_left_q <= '0;
      drain_left_q <= '0;
      lat_sr_q     <= '0;
      full_q       <= '0;
      fill_sel_q   <= 1'b0;
      drain_sel_q  <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      bram_en_q <= 1'b0;
      done_q    <= 1'b0;
      lat_sr_q  <= lat_sr_d;
      full_q    <= full_d;
      case (state_q)
        IDLE: if (start) begin
          state_q      <= RUN;
          busy_q       <= 1'b1;
          bram_en_q    <= 1'b1;
          addr_q       <= start_index;
          fetch_left_q <= line_count - CNTW'(1);
          drain_left_q <= line_count;
        end
        RUN: begin
          if (fetch_go) begin
            bram_en_q    <= 1'b1;
            addr_q       <= addr_q + 1'b1;
            fetch_left_q <= fetch_left_q - 1'b1;
          end
          if (last_beat) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (capture) fill_sel_q <= ~fill_sel_q;
      if (line_end) begin
        drain_sel_q  <= ~drain_sel_q;
        drain_left_q <= drain_left_q - 1'b1;
        word_cnt_q   <= '0;
      end else if (hs) begin
        word_cnt_q   <= word_cnt_q + 1'b1;
      end
    end
  end

  // Line storage needs no reset: the full flags gate everything visible.
  always_ff @(posedge clk) begin
    if (capture) buf_q[fill_sel_q] <= bram_rdata;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bram_en       = bram_en_q;
  assign bram_addr     = addr_q;
  assign m_axis_tvalid = full_q[drain_sel_q];
  assign m_axis_tdata  = m_axis_tvalid ? buf_q[drain_sel_q][word_cnt_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (word_cnt_q == LAST_WORD) && (drain_left_q == CNTW'(1));

endmodule
